// File: rtl/count_check_pkg.sv
// Shared types and helpers for the counter-stream checker.
package count_check_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Consecutive in-sequence samples needed before declaring lock.
    localparam int DEFAULT_LOCK_LEN = 4;

    // Successor of a sampled count, wrapped to 'width' bits (width <= 32).
    function automatic logic [31:0] next_expected(input logic [31:0] value,
                                                  input int unsigned width);
        logic [31:0] r;
        r = value + 32'd1;
        if (width < 32) r = r & ((32'd1 << width) - 32'd1);
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q, value_d;

    // Next value: clear, saturating increment, or hold.
    always_comb begin
        value_d = value_q;
        if (clr)                        value_d = '0;
        else if (inc && value_q != '1)  value_d = value_q + W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/count_stream_checker.sv
// Checks that a sampled counter stream advances by one per valid sample,
// locks after LOCK_LEN good samples and counts slips once locked.
// WIDTH is limited to 32 by the package helper.
module count_stream_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = DEFAULT_LOCK_LEN,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      sample_count,
    output logic [WIDTH-1:0] bad_expected,
    output logic [WIDTH-1:0] bad_actual
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [7:0]       streak_q, streak_d;
    logic             error_q, error_d;
    logic [31:0]      sample_count_q, sample_count_d;
    logic [WIDTH-1:0] bad_expected_q, bad_expected_d;
    logic [WIDTH-1:0] bad_actual_q, bad_actual_d;
    logic             slip;
    logic             match;
    logic [WIDTH-1:0] resync;

    assign match  = in_valid && (in_count == expected_q);
    assign resync = WIDTH'(next_expected(32'(in_count), WIDTH));

    // Next-state and statistics update; clear overrides any sample.
    always_comb begin
        state_d        = state_q;
        expected_d     = expected_q;
        streak_d       = streak_q;
        error_d        = error_q;
        sample_count_d = sample_count_q;
        bad_expected_d = bad_expected_q;
        bad_actual_d   = bad_actual_q;
        slip           = 1'b0;
        if (clear) begin
            state_d        = HUNT;
            expected_d     = '0;
            streak_d       = '0;
            error_d        = 1'b0;
            sample_count_d = '0;
            bad_expected_d = '0;
            bad_actual_d   = '0;
        end else if (in_valid) begin
            sample_count_d = sample_count_q + 32'd1;
            expected_d     = resync;
            unique case (state_q)
                HUNT: begin
                    streak_d = 8'd1;
                    state_d  = (LOCK_LEN == 1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        streak_d = streak_q + 8'd1;
                        if (streak_d == 8'(LOCK_LEN)) state_d = LOCKED;
                    end else begin
                        streak_d = 8'd1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        slip           = 1'b1;
                        error_d        = 1'b1;
                        bad_expected_d = expected_q;
                        bad_actual_d   = in_count;
                        streak_d       = 8'd1;
                        state_d        = (LOCK_LEN == 1) ? LOCKED : ACQUIRE;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q        <= HUNT;
            expected_q     <= '0;
            streak_q       <= '0;
            error_q        <= 1'b0;
            sample_count_q <= '0;
            bad_expected_q <= '0;
            bad_actual_q   <= '0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            streak_q       <= streak_d;
            error_q        <= error_d;
            sample_count_q <= sample_count_d;
            bad_expected_q <= bad_expected_d;
            bad_actual_q   <= bad_actual_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (async_rst_n),
        .inc   (slip),
        .clr   (clear),
        .value (err_count)
    );

    assign locked       = (state_q == LOCKED);
    assign error        = error_q;
    assign sample_count = sample_count_q;
    assign bad_expected = bad_expected_q;
    assign bad_actual   = bad_actual_q;

endmodule

// File: doc/count_stream_checker.md
# count_stream_checker

Receive-side companion to the counter fixtures: consumes a sampled counter stream (cycle, sync-reset or async-reset count) and checks that each valid sample is the previous one plus one, modulo 2^WIDTH. Locks after a run of consecutive good samples and counts slips after lock. Exposes sticky status for Verilator benches and for the on-chip self-test path.

## Interface
- WIDTH, 8: width of the sampled count.
- LOCK_LEN, 4: consecutive in-sequence samples required to declare lock (legal range 1..255).
- ERR_W, 16: width of the slip counter.
- clk  input  1  clock; all logic on posedge.
- async_rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to clk.
- clear  input  1  synchronous soft clear. Returns the block to HUNT and zeroes statistics.
- in_valid  input  1  in_count carries a sample this cycle.
- in_count  input  WIDTH  sampled counter value.
- locked  output  1  state is LOCKED.
- error  output  1  sticky: at least one slip seen since reset or clear.
- err_count  output  ERR_W  number of slips; saturates at all-ones.
- sample_count  output  32  number of valid samples accepted; wraps.
- bad_expected  output  WIDTH  expected value at the most recent slip.
- bad_actual  output  WIDTH  received value at the most recent slip.

## Operation
- State machine states: HUNT, ACQUIRE, LOCKED.
- Internal registers: expected (WIDTH bits) and streak (8 bits).
- A "match" means in_valid and in_count == expected. expected always updates to in_count + 1, truncated to WIDTH bits. Wrap is a match: expected 0 after 255 (WIDTH=8).
- HUNT, on in_valid: expected <= in_count+1, streak <= 1. Go to LOCKED if LOCK_LEN==1, otherwise to ACQUIRE.
- ACQUIRE, on match: streak++. When streak reaches LOCK_LEN, go to LOCKED.
- ACQUIRE, on mismatch: streak <= 1, resync expected. No slip is counted.
- LOCKED, on match: stay in LOCKED.
- LOCKED, on mismatch (a slip): error <= 1, err_count++ (saturating), bad_expected <= expected, bad_actual <= in_count, resync expected, streak <= 1. Go to ACQUIRE, or stay in LOCKED if LOCK_LEN==1.
- Cycles with in_valid low: no state change. Gaps are not errors.
- sample_count increments on every in_valid in every state, unless clear is high.
- clear has priority over in_valid. When both are high, the sample is discarded and state is as after reset.

## Timing
- All outputs are registered. Effect of a sample at edge N is visible after edge N+1 (1-cycle latency).
- Reset values: state HUNT, locked 0, error 0, err_count 0, sample_count 0, bad_expected 0, bad_actual 0, expected 0, streak 0.
- Reset mid-stream: async_rst_n low forces reset values immediately, with no clock needed. The first sample after release is treated as a HUNT sample.
- clear: takes effect at the next edge with the same values as reset. The sample in that cycle is not counted.
- err_count at all-ones stays there; error stays 1. locked still drops on each slip.
- Back-to-back slips in LOCKED (LOCK_LEN==1): each counts as one slip; bad_* hold the latest slip.

## Structure
- Package count_check_pkg holds:
  - state_t enum (HUNT, ACQUIRE, LOCKED);
  - default LOCK_LEN constant;
  - function next_expected(value) that returns value + 1 truncated to WIDTH.
- One sub-module, sat_counter (parameter W, inputs inc/clr, output value, holds at all-ones). Used for err_count.
- sample_count is a plain wrapping register.

## Test plan
- Reset then in_valid with counts 10,11,12,13 (LOCK_LEN=4) -> locked rises one cycle after the 13 edge; err_count 0; sample_count 4.
- Locked stream 253,254,255,0,1 -> no slip; locked stays 1; wrap accepted.
- Locked, then 20,21,25,26,27,28 -> err_count 1, bad_expected 22, bad_actual 25, locked low then high after 28.
- ACQUIRE mismatches (5,9,3 from HUNT) -> error stays 0, err_count 0, locked 0.
- ERR_W=2 with 5 slips -> err_count 3, error 1.
- Async reset pulse mid-stream with no clock edge -> all outputs 0 immediately. clear with in_valid high -> sample_count unchanged from 0, state HUNT.
